// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined ARM-subset controller: opcodes, ALU
// commands, condition codes, flag bit positions and pipeline control bundles.
package ctrl_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_RSB = 4'b0011;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ADC = 4'b0101;
  localparam logic [3:0] CMD_SBC = 4'b0110;
  localparam logic [3:0] CMD_RSC = 4'b0111;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_TEQ = 4'b1001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  typedef enum logic [3:0] {
    CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_VC,
    CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [3:0] cond;
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       pc_src;
    logic [1:0] alu_src;
    logic [3:0] alu_ctrl;
    logic       shift;
    logic [1:0] flag_write;
  } ectrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic mem_to_reg;
    logic pc_src;
  } mctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic pc_src;
  } wctrl_t;

endpackage

// File: rtl/cond_unit.sv
// Combinational condition-code check of a 4-bit cond field against NZCV.
module cond_unit
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      CC_EQ: cond_ex = z;
      CC_NE: cond_ex = ~z;
      CC_CS: cond_ex = c;
      CC_CC: cond_ex = ~c;
      CC_MI: cond_ex = n;
      CC_PL: cond_ex = ~n;
      CC_VS: cond_ex = v;
      CC_VC: cond_ex = ~v;
      CC_HI: cond_ex = c & ~z;
      CC_LS: cond_ex = ~c | z;
      CC_GE: cond_ex = (n == v);
      CC_LT: cond_ex = (n != v);
      CC_GT: cond_ex = ~z & (n == v);
      CC_LE: cond_ex = z | (n != v);
      CC_AL: cond_ex = 1'b1;
      CC_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-high reset, sync clear that
// overrides the load enable.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/cond_pipe_controller.sv
// Pipelined controller: decodes InstrD, carries controls through E, M1..Mn, W
// and owns the architectural NZCV register.
module cond_pipe_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_STAGES = 1,
  parameter int ALUCTRL_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          InstrD,
  input  logic [3:0]           ALUFlagsE,
  input  logic                 FlushE,
  input  logic                 StallE,
  output logic [1:0]           ImmSrcD,
  output logic [1:0]           RegSrcD,
  output logic [1:0]           ALUSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ShiftE,
  output logic                 MemtoRegE,
  output logic                 BranchTakenE,
  output logic                 CondExE,
  output logic                 MemWriteM,
  output logic                 RegWriteM,
  output logic                 PCSrcW,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic [3:0]           FlagsQ
);

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd, cmd;
  logic       is_cmp;
  ectrl_t     de_d, de_q;
  mctrl_t     m_in;
  mctrl_t [MEM_STAGES-1:0] m_q;
  wctrl_t     w_d, w_q;
  logic [3:0] flags_d, flags_q;
  logic       e_adv;
  logic       unused_instr;

  assign op     = InstrD[27:26];
  assign funct  = InstrD[25:20];
  assign rd     = InstrD[15:12];
  assign cmd    = funct[4:1];
  assign is_cmp = (cmd[3:2] == 2'b10);
  assign unused_instr = ^{InstrD[19:16], InstrD[11:0]};

  always_comb begin
    de_d      = '0;
    de_d.cond = InstrD[31:28];
    ImmSrcD   = 2'b00;
    RegSrcD   = 2'b00;
    case (op)
      OP_DP: begin
        if (funct == 6'b010010 && rd == 4'hF) begin
          de_d.branch   = 1'b1;
          de_d.alu_ctrl = CMD_MOV;
        end else begin
          de_d.reg_write = ~is_cmp;
          de_d.pc_src    = ~is_cmp & (rd == 4'hF);
          de_d.alu_src   = 2'b10;
          de_d.shift     = funct[5];
          case (cmd)
            CMD_TST: de_d.alu_ctrl = CMD_AND;
            CMD_TEQ: de_d.alu_ctrl = CMD_EOR;
            CMD_CMP: de_d.alu_ctrl = CMD_SUB;
            CMD_CMN: de_d.alu_ctrl = CMD_ADD;
            default: de_d.alu_ctrl = cmd;
          endcase
          // bit1 updates NZ, bit0 updates CV
          if (cmd == CMD_CMP || cmd == CMD_CMN)      de_d.flag_write = 2'b11;
          else if (cmd == CMD_TST || cmd == CMD_TEQ) de_d.flag_write = 2'b10;
          else if (funct[0])
            de_d.flag_write = (cmd >= CMD_SUB && cmd <= CMD_RSC) ? 2'b11 : 2'b10;
        end
      end
      OP_MEM: begin
        de_d.reg_write  = funct[0];
        de_d.mem_to_reg = funct[0];
        de_d.mem_write  = ~funct[0];
        de_d.alu_ctrl   = funct[3] ? CMD_ADD : CMD_SUB;
        de_d.alu_src    = 2'b01;
        ImmSrcD         = 2'b01;
        RegSrcD         = 2'b10;
      end
      OP_BR: begin
        de_d.branch    = 1'b1;
        de_d.reg_write = funct[4];
        de_d.alu_ctrl  = CMD_ADD;
        de_d.alu_src   = 2'b01;
        ImmSrcD        = 2'b10;
        RegSrcD        = 2'b11;
      end
      default: ;
    endcase
  end

  pipe_reg #(.W($bits(ectrl_t))) u_de (
    .clk(clk), .reset(reset), .en(~StallE), .clr(FlushE), .d(de_d), .q(de_q)
  );

  cond_unit u_cond (.cond(de_q.cond), .flags(flags_q), .cond_ex(CondExE));

  assign ALUSrcE      = de_q.alu_src;
  assign ALUControlE  = ALUCTRL_W'(de_q.alu_ctrl);
  assign ShiftE       = de_q.shift;
  assign MemtoRegE    = de_q.mem_to_reg;
  assign BranchTakenE = de_q.branch & CondExE;

  // A held E instruction commits (flags and M entry) only on the edge it leaves E.
  assign e_adv = CondExE & ~StallE;

  always_comb begin
    flags_d = flags_q;
    if (e_adv & de_q.flag_write[1]) flags_d[3:2] = ALUFlagsE[3:2];
    if (e_adv & de_q.flag_write[0]) flags_d[1:0] = ALUFlagsE[1:0];
  end

  pipe_reg #(.W(4)) u_flags (
    .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .d(flags_d), .q(flags_q)
  );
  assign FlagsQ = flags_q;

  always_comb begin
    m_in            = '0;
    m_in.reg_write  = de_q.reg_write & e_adv;
    m_in.mem_write  = de_q.mem_write & e_adv;
    m_in.pc_src     = de_q.pc_src & e_adv;
    m_in.mem_to_reg = de_q.mem_to_reg & ~StallE;
  end

  for (genvar i = 0; i < MEM_STAGES; i++) begin : g_m
    if (i == 0) begin : g_first
      pipe_reg #(.W($bits(mctrl_t))) u_m (
        .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .d(m_in), .q(m_q[0])
      );
    end else begin : g_next
      pipe_reg #(.W($bits(mctrl_t))) u_m (
        .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .d(m_q[i-1]), .q(m_q[i])
      );
    end
  end

  assign MemWriteM = m_q[MEM_STAGES-1].mem_write;
  assign RegWriteM = m_q[MEM_STAGES-1].reg_write;

  always_comb begin
    w_d            = '0;
    w_d.reg_write  = m_q[MEM_STAGES-1].reg_write;
    w_d.mem_to_reg = m_q[MEM_STAGES-1].mem_to_reg;
    w_d.pc_src     = m_q[MEM_STAGES-1].pc_src;
  end

  pipe_reg #(.W($bits(wctrl_t))) u_w (
    .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .d(w_d), .q(w_q)
  );

  assign RegWriteW = w_q.reg_write;
  assign MemtoRegW = w_q.mem_to_reg;
  assign PCSrcW    = w_q.pc_src;

endmodule

// File: tb/tb_cond_pipe_controller.sv
// Directed bench for cond_pipe_controller with three memory stages.
module tb_cond_pipe_controller;

  localparam int MS = 3;
  localparam logic [31:0] NOP  = 32'hF000_0000;
  localparam logic [31:0] ADDS = 32'hE092_1003;
  localparam logic [31:0] CMP5 = 32'hE351_0005;
  localparam logic [31:0] BEQ  = 32'h0A00_0002;
  localparam logic [31:0] BXLR = 32'hE12F_FF1E;
  localparam logic [31:0] LDR  = 32'hE591_0004;
  localparam logic [31:0] STR  = 32'hE581_0004;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD;
  logic [3:0]  ALUFlagsE;
  logic        FlushE, StallE;
  logic [1:0]  ImmSrcD, RegSrcD, ALUSrcE;
  logic [3:0]  ALUControlE;
  logic        ShiftE, MemtoRegE, BranchTakenE, CondExE;
  logic        MemWriteM, RegWriteM, PCSrcW, RegWriteW, MemtoRegW;
  logic [3:0]  FlagsQ;

  int checks = 0;
  int failures = 0;

  cond_pipe_controller #(.MEM_STAGES(MS), .ALUCTRL_W(4)) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlagsE(ALUFlagsE),
    .FlushE(FlushE), .StallE(StallE), .ImmSrcD(ImmSrcD), .RegSrcD(RegSrcD),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .ShiftE(ShiftE),
    .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .CondExE(CondExE),
    .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .PCSrcW(PCSrcW),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .FlagsQ(FlagsQ)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; InstrD = NOP; ALUFlagsE = 4'h0; FlushE = 1'b0; StallE = 1'b0;
    step(); step();
    checks++; if (FlagsQ !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", FlagsQ); end
    checks++; if ({ALUSrcE, ALUControlE, ShiftE, MemtoRegE, BranchTakenE, CondExE} !== 10'b0) begin
      failures++; $display("FAIL reset_e got=%b exp=0", {ALUSrcE, ALUControlE, ShiftE, MemtoRegE, BranchTakenE, CondExE}); end
    checks++; if ({MemWriteM, RegWriteM, PCSrcW, RegWriteW, MemtoRegW} !== 5'b0) begin
      failures++; $display("FAIL reset_mw got=%b exp=00000", {MemWriteM, RegWriteM, PCSrcW, RegWriteW, MemtoRegW}); end
    reset = 1'b0;
  endtask

  task automatic test_adds();
    InstrD = ADDS; #1;
    checks++; if ({ImmSrcD, RegSrcD} !== 4'b0000) begin failures++; $display("FAIL adds_dec got=%b exp=0000", {ImmSrcD, RegSrcD}); end
    step();
    checks++; if (ALUControlE !== 4'b0100) begin failures++; $display("FAIL adds_aluctl got=%b exp=0100", ALUControlE); end
    checks++; if ({ALUSrcE, ShiftE, CondExE} !== 4'b1001) begin failures++; $display("FAIL adds_esig got=%b exp=1001", {ALUSrcE, ShiftE, CondExE}); end
    ALUFlagsE = 4'b0110; InstrD = NOP;
    step();
    checks++; if (FlagsQ !== 4'b0110) begin failures++; $display("FAIL adds_flags got=%b exp=0110", FlagsQ); end
    checks++; if (RegWriteM !== 1'b0) begin failures++; $display("FAIL adds_rwm_early got=%b exp=0", RegWriteM); end
    step(); step();
    checks++; if (RegWriteM !== 1'b1) begin failures++; $display("FAIL adds_rwm got=%b exp=1", RegWriteM); end
    step();
    checks++; if ({RegWriteW, MemtoRegW, PCSrcW, RegWriteM} !== 4'b1000) begin
      failures++; $display("FAIL adds_w got=%b exp=1000", {RegWriteW, MemtoRegW, PCSrcW, RegWriteM}); end
  endtask

  task automatic test_cmp_beq(input logic [3:0] f, input logic taken);
    InstrD = CMP5;
    step();
    checks++; if ({ALUControlE, ShiftE, ALUSrcE} !== 7'b0010110) begin
      failures++; $display("FAIL cmp_e got=%b exp=0010110", {ALUControlE, ShiftE, ALUSrcE}); end
    ALUFlagsE = f; InstrD = BEQ; #1;
    checks++; if ({ImmSrcD, RegSrcD} !== 4'b1011) begin failures++; $display("FAIL beq_dec got=%b exp=1011", {ImmSrcD, RegSrcD}); end
    step();
    checks++; if (FlagsQ !== f) begin failures++; $display("FAIL cmp_flags got=%b exp=%b", FlagsQ, f); end
    checks++; if ({BranchTakenE, CondExE} !== {taken, taken}) begin
      failures++; $display("FAIL beq_taken got=%b exp=%b", {BranchTakenE, CondExE}, {taken, taken}); end
    InstrD = NOP;
    step(); step();
    checks++; if (RegWriteM !== 1'b0) begin failures++; $display("FAIL cmp_rwm got=%b exp=0", RegWriteM); end
    step(); step();
  endtask

  task automatic test_bx();
    InstrD = BXLR;
    step();
    checks++; if ({BranchTakenE, ALUControlE, ALUSrcE} !== 7'b1110100) begin
      failures++; $display("FAIL bx_e got=%b exp=1110100", {BranchTakenE, ALUControlE, ALUSrcE}); end
    InstrD = NOP;
    step(); step(); step();
    checks++; if ({RegWriteM, MemWriteM} !== 2'b00) begin failures++; $display("FAIL bx_m got=%b exp=00", {RegWriteM, MemWriteM}); end
    step();
    checks++; if ({PCSrcW, RegWriteW} !== 2'b00) begin failures++; $display("FAIL bx_w got=%b exp=00", {PCSrcW, RegWriteW}); end
  endtask

  task automatic test_ldr_str();
    InstrD = LDR; #1;
    checks++; if ({ImmSrcD, RegSrcD} !== 4'b0110) begin failures++; $display("FAIL ldr_dec got=%b exp=0110", {ImmSrcD, RegSrcD}); end
    step();
    checks++; if ({MemtoRegE, ALUSrcE, ALUControlE} !== 7'b1010100) begin
      failures++; $display("FAIL ldr_e got=%b exp=1010100", {MemtoRegE, ALUSrcE, ALUControlE}); end
    InstrD = STR;
    step();
    checks++; if (MemtoRegE !== 1'b0) begin failures++; $display("FAIL str_e got=%b exp=0", MemtoRegE); end
    InstrD = NOP;
    step(); step();
    checks++; if ({RegWriteM, MemWriteM} !== 2'b10) begin failures++; $display("FAIL ldr_m got=%b exp=10", {RegWriteM, MemWriteM}); end
    step();
    checks++; if ({RegWriteW, MemtoRegW, MemWriteM} !== 3'b111) begin
      failures++; $display("FAIL ldr_w_str_m got=%b exp=111", {RegWriteW, MemtoRegW, MemWriteM}); end
    step();
    checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL str_w got=%b exp=0", RegWriteW); end
  endtask

  task automatic test_flush_stall();
    InstrD = CMP5;
    step();
    FlushE = 1'b1; StallE = 1'b1; ALUFlagsE = 4'b1001; InstrD = NOP;
    step();
    checks++; if ({ALUControlE, ALUSrcE, ShiftE} !== 7'b0) begin
      failures++; $display("FAIL flush_e got=%b exp=0000000", {ALUControlE, ALUSrcE, ShiftE}); end
    checks++; if (FlagsQ !== 4'b0000) begin failures++; $display("FAIL flush_flags got=%b exp=0000", FlagsQ); end
    FlushE = 1'b0; StallE = 1'b0;
    step();
  endtask

  task automatic test_stall();
    int cnt;
    InstrD = ADDS;
    step();
    StallE = 1'b1; ALUFlagsE = 4'b1010; InstrD = NOP;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ALUControlE !== 4'b0100) begin failures++; $display("FAIL stall_hold%0d got=%b exp=0100", i, ALUControlE); end
      checks++; if (FlagsQ !== 4'b0000) begin failures++; $display("FAIL stall_flags%0d got=%b exp=0000", i, FlagsQ); end
    end
    StallE = 1'b0;
    step();
    checks++; if ({FlagsQ, ALUControlE} !== 8'b1010_0000) begin
      failures++; $display("FAIL stall_release got=%b exp=10100000", {FlagsQ, ALUControlE}); end
    ALUFlagsE = 4'b0101;
    cnt = int'(RegWriteM);
    for (int i = 0; i < 3; i++) begin
      step();
      cnt += int'(RegWriteM);
    end
    checks++; if (FlagsQ !== 4'b1010) begin failures++; $display("FAIL stall_once_flags got=%b exp=1010", FlagsQ); end
    checks++; if (cnt != 1) begin failures++; $display("FAIL stall_once_rwm got=%0d exp=1", cnt); end
  endtask

  task automatic test_reset_mid();
    InstrD = ADDS;
    step();
    ALUFlagsE = 4'b1111; InstrD = NOP;
    step(); step(); step();
    checks++; if ({RegWriteM, FlagsQ} !== 5'b11111) begin failures++; $display("FAIL pre_reset got=%b exp=11111", {RegWriteM, FlagsQ}); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({RegWriteM, MemWriteM, FlagsQ, ALUControlE, CondExE} !== 11'b0) begin
      failures++; $display("FAIL mid_reset got=%b exp=0", {RegWriteM, MemWriteM, FlagsQ, ALUControlE, CondExE}); end
    step();
    reset = 1'b0; InstrD = LDR;
    step();
    checks++; if (MemtoRegE !== 1'b1) begin failures++; $display("FAIL post_reset_e got=%b exp=1", MemtoRegE); end
    InstrD = NOP;
    step(); step(); step();
    checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL post_reset_w3 got=%b exp=0", RegWriteW); end
    step();
    checks++; if ({RegWriteW, MemtoRegW} !== 2'b11) begin failures++; $display("FAIL post_reset_w4 got=%b exp=11", {RegWriteW, MemtoRegW}); end
  endtask

  initial begin
    test_reset();
    test_adds();
    test_cmp_beq(4'b0100, 1'b1);
    test_cmp_beq(4'b0000, 1'b0);
    test_bx();
    test_ldr_str();
    test_flush_stall();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
